// File: rtl/wbuf_pkg.sv
// Shared types and helpers for the ping-pong weight buffer.
package wbuf_pkg;
   typedef enum logic {W_IDLE, W_FILL}   wstate_t;
   typedef enum logic {R_IDLE, R_STREAM} rstate_t;

   localparam int BANKS = 2;
   localparam int LEN_W = 9;   // holds 1..256

   // Zero becomes 1 and anything beyond the bank depth is clamped.
   function automatic logic [LEN_W-1:0] eff_len(input logic [7:0] len, input int depth);
      if (len == 8'd0) return LEN_W'(1);
      if (int'(len) > depth) return LEN_W'(depth);
      return {1'b0, len};
   endfunction
endpackage

// File: rtl/wbuf_bank.sv
// One weight bank: flop storage, combinational read port, per-bank length/replay registers.
module wbuf_bank
   import wbuf_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 64,
   parameter int ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  we,
   input  logic [ADDR_W-1:0]     waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic                  cfg_we,
   input  logic [LEN_W-1:0]      len_in,
   input  logic [7:0]            reps_in,
   input  logic [ADDR_W-1:0]     raddr,
   output logic [DATA_WIDTH-1:0] rdata,
   output logic [LEN_W-1:0]      len_q,
   output logic [7:0]            reps_q
);
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         len_q  <= LEN_W'(1);
         reps_q <= 8'd0;
      end else if (cfg_we) begin
         len_q  <= len_in;
         reps_q <= reps_in;
      end
   end

   assign rdata = mem[raddr];
endmodule

// File: rtl/weight_pingpong_buf.sv
// Ping-pong weight buffer: loads one bank while replaying the other to a PE column.
// Optional WBUF_CFG_CHECK_EN rejects illegal cfg_len and raises a sticky cfg_err.
module weight_pingpong_buf
   import wbuf_pkg::*;
#(
   parameter int DATA_WIDTH = 16,
   parameter int DEPTH      = 64,
   parameter int ADDR_W     = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rstn,
   input  logic                  flush,
   input  logic [7:0]            cfg_len,
   input  logic [7:0]            cfg_reps,
   input  logic                  wr_valid,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic                  wr_ready,
   output logic                  rd_valid,
   output logic [DATA_WIDTH-1:0] rd_data,
   input  logic                  rd_ready,
   output logic                  rd_last,
   output logic                  rd_bank_done,
   output logic [1:0]            bank_full
`ifdef WBUF_CFG_CHECK_EN
   ,
   output logic                  cfg_err
`endif
);
   wstate_t wstate;
   rstate_t rstate;
   logic                 wr_bank, rd_bank;
   logic [ADDR_W-1:0]    wr_ptr, rd_ptr;
   logic [7:0]           pass_cnt;

   logic [BANKS-1:0][DATA_WIDTH-1:0] b_rdata;
   logic [BANKS-1:0][LEN_W-1:0]      b_len;
   logic [BANKS-1:0][7:0]            b_reps;
   logic [BANKS-1:0]                 b_we, b_cfg_we, set_full, clr_full;

   logic [LEN_W-1:0] cap_len, wlen, rlen;
   logic [7:0]       reps_eff;
   logic             cfg_bad, wr_fire, wr_done, rd_fire, rd_end;

   always_comb begin
      cap_len  = eff_len(cfg_len, DEPTH);
`ifdef WBUF_CFG_CHECK_EN
      cfg_bad  = (wstate == W_IDLE) && ((cfg_len == 8'd0) || (int'(cfg_len) > DEPTH));
`else
      cfg_bad  = 1'b0;
`endif
      wr_ready = !bank_full[wr_bank] && !cfg_bad;
      wr_fire  = wr_valid && wr_ready;
      // The first word of a load compares against the length being captured right now.
      wlen     = (wstate == W_IDLE) ? cap_len : b_len[wr_bank];
      wr_done  = wr_fire && (LEN_W'(wr_ptr) == wlen - LEN_W'(1));

      rlen     = b_len[rd_bank];
      reps_eff = (b_reps[rd_bank] == 8'd0) ? 8'd1 : b_reps[rd_bank];
      rd_valid = (rstate == R_STREAM);
      rd_data  = rd_valid ? b_rdata[rd_bank] : '0;
      rd_last  = rd_valid && (LEN_W'(rd_ptr) == rlen - LEN_W'(1));
      rd_fire  = rd_valid && rd_ready;
      rd_end   = rd_fire && rd_last && (pass_cnt == reps_eff - 8'd1);

      for (int b = 0; b < BANKS; b++) begin
         b_we[b]     = wr_fire && (wr_bank == 1'(b));
         b_cfg_we[b] = b_we[b] && (wstate == W_IDLE);
         set_full[b] = wr_done && (wr_bank == 1'(b));
         clr_full[b] = rd_end && (rd_bank == 1'(b));
      end
   end

   for (genvar g = 0; g < BANKS; g++) begin : g_bank
      wbuf_bank #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank (
         .clk    (clk),
         .rstn   (rstn),
         .we     (b_we[g]),
         .waddr  (wr_ptr),
         .wdata  (wr_data),
         .cfg_we (b_cfg_we[g]),
         .len_in (cap_len),
         .reps_in(cfg_reps),
         .raddr  (rd_ptr),
         .rdata  (b_rdata[g]),
         .len_q  (b_len[g]),
         .reps_q (b_reps[g])
      );
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wstate  <= W_IDLE;
         wr_bank <= 1'b0;
         wr_ptr  <= '0;
      end else if (flush) begin
         wstate  <= W_IDLE;
         wr_bank <= 1'b0;
         wr_ptr  <= '0;
      end else if (wr_fire) begin
         if (wr_done) begin
            wr_ptr  <= '0;
            wr_bank <= ~wr_bank;
            wstate  <= W_IDLE;
         end else begin
            wr_ptr  <= wr_ptr + ADDR_W'(1);
            wstate  <= W_FILL;
         end
      end
   end

   // Read FSM also owns the full flags, since both sides update them.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         rstate       <= R_IDLE;
         rd_bank      <= 1'b0;
         rd_ptr       <= '0;
         pass_cnt     <= 8'd0;
         bank_full    <= 2'b00;
         rd_bank_done <= 1'b0;
      end else if (flush) begin
         rstate       <= R_IDLE;
         rd_bank      <= 1'b0;
         rd_ptr       <= '0;
         pass_cnt     <= 8'd0;
         bank_full    <= 2'b00;
         rd_bank_done <= 1'b0;
      end else begin
         bank_full    <= (bank_full | set_full) & ~clr_full;
         rd_bank_done <= rd_end;
         case (rstate)
            R_IDLE:
               if (bank_full[rd_bank]) rstate <= R_STREAM;
            R_STREAM:
               if (rd_fire) begin
                  if (rd_last) begin
                     rd_ptr <= '0;
                     if (rd_end) begin
                        pass_cnt <= 8'd0;
                        rd_bank  <= ~rd_bank;
                        rstate   <= bank_full[~rd_bank] ? R_STREAM : R_IDLE;
                     end else begin
                        pass_cnt <= pass_cnt + 8'd1;
                     end
                  end else begin
                     rd_ptr <= rd_ptr + ADDR_W'(1);
                  end
               end
            default: rstate <= R_IDLE;
         endcase
      end
   end

`ifdef WBUF_CFG_CHECK_EN
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn)                        cfg_err <= 1'b0;
      else if (flush)                   cfg_err <= 1'b0;
      else if (wr_valid && cfg_bad && !bank_full[wr_bank]) cfg_err <= 1'b1;
   end
`endif
endmodule

// File: tb/tb_weight_pingpong_buf.sv
// Directed bench for weight_pingpong_buf; a negedge monitor records every read handshake.
module tb_weight_pingpong_buf;
   localparam int DW = 16;
   localparam int DEPTH = 64;

   logic clk = 1'b0, rstn = 1'b0, flush = 1'b0;
   logic [7:0] cfg_len = 8'd0, cfg_reps = 8'd0;
   logic wr_valid = 1'b0, rd_ready = 1'b0;
   logic [DW-1:0] wr_data = '0;
   logic wr_ready, rd_valid, rd_last, rd_bank_done;
   logic [DW-1:0] rd_data;
   logic [1:0] bank_full;
`ifdef WBUF_CFG_CHECK_EN
   logic cfg_err;
`endif

   weight_pingpong_buf #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
      .clk(clk), .rstn(rstn), .flush(flush), .cfg_len(cfg_len), .cfg_reps(cfg_reps),
      .wr_valid(wr_valid), .wr_data(wr_data), .wr_ready(wr_ready),
      .rd_valid(rd_valid), .rd_data(rd_data), .rd_ready(rd_ready),
      .rd_last(rd_last), .rd_bank_done(rd_bank_done), .bank_full(bank_full)
`ifdef WBUF_CFG_CHECK_EN
      , .cfg_err(cfg_err)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0, n_err = 0, cyc = 0, done_cnt = 0;
   int got_q[$], stamp_q[$], exp_q[$];
   bit last_q[$], exp_last_q[$];
   bit stall_prev = 1'b0, wb = 1'b0;
   logic [DW-1:0] prev_data = '0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rstn && !flush) begin
         if (rd_valid && rd_ready) begin
            got_q.push_back(int'(rd_data));
            last_q.push_back(rd_last);
            stamp_q.push_back(cyc);
         end
         if (rd_bank_done) done_cnt++;
         if (stall_prev && rd_valid) chk("stall_hold", 32'(rd_data), 32'(prev_data));
      end
      stall_prev = rstn && !flush && rd_valid && !rd_ready;
      prev_data  = rd_data;
   end

   task automatic step();
      @(posedge clk); #1;
   endtask

   task automatic write_word(input int d);
      int k = 0;
      wr_valid = 1'b1;
      wr_data  = DW'(d);
      #1;
      while (!wr_ready && k < 200) begin
         @(posedge clk); #2; k++;
      end
      if (k >= 200) chk("wr_timeout", 32'(wr_ready), 32'd1);
      @(posedge clk); #1;
      wr_valid = 1'b0;
   endtask

   task automatic load(input int len, input int reps, input int base, input int n);
      cfg_len  = 8'(len);
      cfg_reps = 8'(reps);
      for (int i = 0; i < n; i++) write_word(base + i);
      wb = ~wb;
   endtask

   task automatic clear_q();
      got_q.delete(); stamp_q.delete(); last_q.delete();
      exp_q.delete(); exp_last_q.delete();
      done_cnt = 0;
   endtask

   task automatic drain(input int budget, input bit tog);
      int k = 0;
      while (!(!rd_valid && bank_full == 2'b00) && k < budget) begin
         rd_ready = tog ? ~rd_ready : 1'b1;
         step(); k++;
      end
      if (k >= budget) chk("drain_timeout", 32'(bank_full), 32'd0);
      step();
      rd_ready = 1'b1;
   endtask

   task automatic check_stream(input string tag, input int dones, input bit contig);
      chk({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
         chk($sformatf("%s_data%0d", tag, i), 32'(got_q[i]), 32'(exp_q[i]));
         chk($sformatf("%s_last%0d", tag, i), 32'(last_q[i]), 32'(exp_last_q[i]));
      end
      chk({tag, "_done"}, 32'(done_cnt), 32'(dones));
      if (contig && got_q.size() > 1)
         chk({tag, "_gapless"}, 32'(stamp_q[stamp_q.size()-1] - stamp_q[0]), 32'(got_q.size() - 1));
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_wr_ready"}, 32'(wr_ready), 32'd1);
      chk({tag, "_rd_valid"}, 32'(rd_valid), 32'd0);
      chk({tag, "_rd_data"},  32'(rd_data), 32'd0);
      chk({tag, "_rd_last"},  32'(rd_last), 32'd0);
      chk({tag, "_done"},     32'(rd_bank_done), 32'd0);
      chk({tag, "_full"},     32'(bank_full), 32'd0);
`ifdef WBUF_CFG_CHECK_EN
      chk({tag, "_cfg_err"},  32'(cfg_err), 32'd0);
`endif
   endtask

   initial begin
      bit a_bank;
      int k;
      logic pw;
      #1;
      check_reset("rst");
      repeat (2) @(posedge clk);
      #1 rstn = 1'b1;
      step();

      // single load, no replay; first word one cycle after the load completes
      clear_q(); rd_ready = 1'b1;
      load(9, 1, 1, 9);
      chk("lat_pre_valid", 32'(rd_valid), 32'd0);
      chk("lat_full", 32'(bank_full), 32'd1);
      step();
      chk("lat_valid", 32'(rd_valid), 32'd1);
      chk("lat_data", 32'(rd_data), 32'd1);
      for (int i = 1; i <= 9; i++) begin exp_q.push_back(i); exp_last_q.push_back(i == 9); end
      drain(40, 1'b0);
      check_stream("single", 1, 1'b1);

      // replay x3 with toggling rd_ready
      clear_q(); rd_ready = 1'b0;
      load(4, 3, 1, 4);
      for (int r = 0; r < 3; r++)
         for (int i = 1; i <= 4; i++) begin exp_q.push_back(i); exp_last_q.push_back(i == 4); end
      drain(80, 1'b1);
      check_stream("replay", 1, 1'b0);

      // ping-pong overlap
      clear_q(); rd_ready = 1'b1;
      a_bank = wb;
      load(4, 2, 1, 4);
      load(4, 1, 5, 4);
      chk("pp_both_full", 32'(bank_full), 32'd3);
      chk("pp_wr_ready_low", 32'(wr_ready), 32'd0);
      k = 0; pw = wr_ready;
      while (!rd_bank_done && k < 40) begin pw = wr_ready; step(); k++; end
      chk("pp_free_prev", 32'(pw), 32'd0);
      chk("pp_free_rdy", 32'(wr_ready), 32'd1);
      chk("pp_free_full", 32'(bank_full), a_bank ? 32'd1 : 32'd2);
      for (int r = 0; r < 2; r++)
         for (int i = 1; i <= 4; i++) begin exp_q.push_back(i); exp_last_q.push_back(i == 4); end
      for (int i = 5; i <= 8; i++) begin exp_q.push_back(i); exp_last_q.push_back(i == 8); end
      drain(40, 1'b0);
      check_stream("pp", 2, 1'b1);

      // cfg_len = 1: every word is last
      clear_q();
      load(1, 1, 7, 1); load(1, 1, 8, 1); load(1, 1, 9, 1);
      for (int i = 7; i <= 9; i++) begin exp_q.push_back(i); exp_last_q.push_back(1'b1); end
      drain(40, 1'b0);
      check_stream("len1", 3, 1'b0);

      // cfg_len = DEPTH
      clear_q();
      load(DEPTH, 1, 100, DEPTH);
      for (int i = 0; i < DEPTH; i++) begin exp_q.push_back(100 + i); exp_last_q.push_back(i == DEPTH-1); end
      drain(200, 1'b0);
      check_stream("depth", 1, 1'b1);

      // cfg_len = 0
      clear_q();
`ifdef WBUF_CFG_CHECK_EN
      cfg_len = 8'd0; cfg_reps = 8'd1;
      wr_valid = 1'b1; wr_data = DW'(16'h55);
      #1;
      chk("len0_wr_ready", 32'(wr_ready), 32'd0);
      step();
      wr_valid = 1'b0;
      chk("len0_cfg_err", 32'(cfg_err), 32'd1);
      chk("len0_full", 32'(bank_full), 32'd0);
      flush = 1'b1; step(); flush = 1'b0;
      chk("len0_err_clr", 32'(cfg_err), 32'd0);
      wb = 1'b0;
`else
      load(0, 1, 16'h55, 1);
      chk("len0_full", 32'(bank_full != 2'b00), 32'd1);
      exp_q.push_back(16'h55); exp_last_q.push_back(1'b1);
      drain(20, 1'b0);
      check_stream("len0", 1, 1'b0);
`endif

      // flush at word 3 of 9
      clear_q(); rd_ready = 1'b1;
      load(9, 1, 1, 9);
      k = 0;
      while (!(rd_valid && rd_data == DW'(3)) && k < 40) begin step(); k++; end
      chk("fl_word3", 32'(rd_data), 32'd3);
      flush = 1'b1; step(); flush = 1'b0;
      wb = 1'b0;
      chk("fl_valid", 32'(rd_valid), 32'd0);
      chk("fl_full", 32'(bank_full), 32'd0);
      chk("fl_wr_ready", 32'(wr_ready), 32'd1);
      chk("fl_data", 32'(rd_data), 32'd0);
      clear_q();
      load(4, 1, 11, 4);
      for (int i = 11; i <= 14; i++) begin exp_q.push_back(i); exp_last_q.push_back(i == 14); end
      drain(40, 1'b0);
      check_stream("fl_after", 1, 1'b1);

      // async reset while one bank stalls and the other is mid-load
      rd_ready = 1'b0;
      load(2, 5, 21, 2);
      step();
      chk("ar_pre_valid", 32'(rd_valid), 32'd1);
      chk("ar_pre_data", 32'(rd_data), 32'd21);
      cfg_len = 8'd9; cfg_reps = 8'd1;
      write_word(31); write_word(32); write_word(33);
      #3 rstn = 1'b0;
      #1 check_reset("ar");
      @(posedge clk); #1 rstn = 1'b1;
      step();
      check_reset("ar_post");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
